// File: rtl/palette_lut.sv
// Programmable colour-index to RGB palette for the VGA output path.
// After reset the palette RAM is filled with the legacy 5-bit default table, one entry per
// cycle. Pixel index, display-enable and syncs then pass through a two-stage pipeline, so
// colour and timing leave the block aligned.
module palette_lut #(
   parameter int unsigned CI_W = 5,
   parameter int unsigned CH_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CI_W-1:0]     pix_idx,
   input  logic                pix_de,
   input  logic                pix_hs,
   input  logic                pix_vs,
   input  logic                wr_en,
   input  logic [CI_W-1:0]     wr_idx,
   input  logic [3*CH_W-1:0]   wr_rgb,
   output logic                wr_ready,
   output logic                init_busy,
   output logic [3*CH_W-1:0]   vga_rgb,
   output logic                vga_de,
   output logic                vga_hs,
   output logic                vga_vs
);

   localparam int unsigned RGB_W = 3 * CH_W;
   localparam int unsigned DEPTH = 1 << CI_W;

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e            state_q, state_d;
   logic [CI_W-1:0]   cnt_q, cnt_d;

   // Palette RAM write port, shared by the init loader and host writes
   logic              ram_we;
   logic [CI_W-1:0]   ram_wa;
   logic [RGB_W-1:0]  ram_wd;
   logic [RGB_W-1:0]  mem [DEPTH];

   // Stage 1: registered pixel inputs
   logic [CI_W-1:0]   idx1_q;
   logic              de1_q, hs1_q, vs1_q;
   // Stage 2: RAM read data plus delayed controls
   logic [RGB_W-1:0]  rgb2_q;
   logic              de2_q, hs2_q, vs2_q;

   // Legacy 12-bit default palette; everything not listed is black.
   function automatic logic [11:0] default_rgb12(input logic [CI_W-1:0] i);
      logic [11:0] c;
      case (int'(i))
         0:       c = 12'h000;
         1:       c = 12'hF00;
         2:       c = 12'h0F0;
         3:       c = 12'h00F;
         4:       c = 12'h007;
         5:       c = 12'h0F0;
         6:       c = 12'h0FF;
         7:       c = 12'hE00;
         8:       c = 12'hE07;
         9:       c = 12'hDF0;
         10:      c = 12'hCCD;
         11:      c = 12'hDDF;
         12:      c = 12'h0FF;
         13:      c = 12'hF0F;
         14:      c = 12'hFF0;
         15:      c = 12'hFC8;
         16:      c = 12'hF0F;
         17:      c = 12'h9F9;
         31:      c = 12'hFFF;
         default: c = 12'h000;
      endcase
      return c;
   endfunction

   // Widen a nibble by replicating its MSB below it, or keep only its top CH_W bits.
   function automatic logic [CH_W-1:0] scale_nib(input logic [3:0] nib);
      logic [CH_W-1:0] r;
      int              k;
      r = '0;
      for (int b = 0; b < int'(CH_W); b++) begin
         k    = int'(CH_W) - 1 - b;
         r[b] = (k < 4) ? nib[3-k] : nib[3];
      end
      return r;
   endfunction

   function automatic logic [RGB_W-1:0] default_rgb(input logic [CI_W-1:0] i);
      logic [11:0] c;
      c = default_rgb12(i);
      return {scale_nib(c[11:8]), scale_nib(c[7:4]), scale_nib(c[3:0])};
   endfunction

   // Init sequencing: walk every entry once, then run
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StInit: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d = StRun;
            end
         end
         StRun: begin
         end
         default: state_d = StInit;
      endcase
   end

   // Select the RAM write source; host writes are ignored while loading defaults
   always_comb begin
      ram_we = 1'b0;
      ram_wa = wr_idx;
      ram_wd = wr_rgb;
      if (!reset) begin
         if (state_q == StInit) begin
            ram_we = 1'b1;
            ram_wa = cnt_q;
            ram_wd = default_rgb(cnt_q);
         end else if (wr_en) begin
            ram_we = 1'b1;
         end
      end
   end

   // FSM state, init counter and read pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StInit;
         cnt_q   <= '0;
         idx1_q  <= '0;
         de1_q   <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         rgb2_q  <= '0;
         de2_q   <= 1'b0;
         hs2_q   <= 1'b0;
         vs2_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx1_q  <= pix_idx;
         de1_q   <= pix_de;
         hs1_q   <= pix_hs;
         vs1_q   <= pix_vs;
         // Same-edge write to this entry is not visible here: old colour is returned
         rgb2_q  <= mem[idx1_q];
         de2_q   <= de1_q;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
      end
   end

   // Single write port into the palette RAM
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_wa] <= ram_wd;
      end
   end

   // Outputs: blank colour outside active video and while the palette is loading
   always_comb begin
      init_busy = (state_q == StInit);
      wr_ready  = (state_q == StRun);
      vga_rgb   = (de2_q && state_q == StRun) ? rgb2_q : '0;
      vga_de    = de2_q;
      vga_hs    = hs2_q;
      vga_vs    = vs2_q;
   end

endmodule
